// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_uart_pkg                                             |
// | Purpose  : Shared types and constants for the FIFO-fed UART          |
// |            transmitter: state encoding, parity-bit count and the     |
// |            frame-length helper.                                      |
// | Macro    : FIFO_UART_PARITY_EN adds the even-parity state/bit.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fifo_uart_pkg;

`ifdef FIFO_UART_PARITY_EN
  localparam int P = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_STOP   = 3'd4,
    ST_PARITY = 3'd5
  } state_t;
`else
  localparam int P = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;
`endif

  // Serial frame length in clock cycles, measured from the start-bit edge.
  function automatic int frame_len(input int n, input int clks_per_bit,
                                   input int stop_bits);
    return (1 + n + P + stop_bits) * clks_per_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_baud_gen                                             |
// | Purpose  : Bit-period counter. Emits a one-cycle bit_tick in the     |
// |            last cycle of every CLKS_PER_BIT-cycle bit period;        |
// |            clear restarts the period from zero.                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] c_last_cnt = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Free-running modulo-CLKS_PER_BIT counter, restarted by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == c_last_cnt)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_tick = (r_cnt == c_last_cnt) && !clear;

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_uart_tx                                              |
// | Purpose  : FIFO read-side consumer. Pops one word when the FIFO is   |
// |            non-empty and serializes it as start bit, N data bits     |
// |            LSB first, optional even parity, and stop bit(s).         |
// | Macro    : FIFO_UART_PARITY_EN enables the even-parity bit.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             tx_en,
  input  logic             fifo_Empty,
  input  logic [N-1:0]     rd_data,
  output logic             rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BIT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BIT_W-1:0] c_last_bit  = BIT_W'(N - 1);
  localparam logic             c_last_stop = 1'(STOP_BITS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_shift;
  logic [N-1:0]     w_shift_next;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [BIT_W-1:0] w_bit_cnt_next;
  logic             r_stop_cnt;
  logic             w_stop_cnt_next;
  logic             r_tx;
  logic             w_tx_next;
  logic             w_rd_en;
  logic             w_tx_done;
  logic             w_bit_tick;
  logic             w_baud_clear;
  logic [CNT_W-1:0] r_frame_cnt;

`ifdef FIFO_UART_PARITY_EN
  logic             r_parity;
`endif

  // The bit period restarts whenever a new frame is being set up
  assign w_baud_clear = (r_state == ST_IDLE) || (r_state == ST_LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (rd_clk),
    .rst_n    (rd_rst),
    .clear    (w_baud_clear),
    .bit_tick (w_bit_tick)
  );

  // State register
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, datapath next values, strobes, and the next line level
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_rd_en         = 1'b0;
    w_tx_done       = 1'b0;
    w_tx_next       = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (tx_en && !fifo_Empty) begin
          w_rd_en      = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_shift_next    = rd_data;
        w_bit_cnt_next  = '0;
        w_stop_cnt_next = 1'b0;
        w_state_next    = ST_START;
      end
      ST_START: begin
        if (w_bit_tick) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_tick) begin
          if (r_bit_cnt == c_last_bit) begin
`ifdef FIFO_UART_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end else begin
            w_shift_next   = {1'b0, r_shift[N-1:1]};
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_PARITY_EN
      ST_PARITY: begin
        if (w_bit_tick) begin
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_tick) begin
          if (r_stop_cnt == c_last_stop) begin
            w_tx_done    = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // The line level is derived from where the FSM is heading so that the
    // registered tx lines up exactly with the state it belongs to.
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef FIFO_UART_PARITY_EN
      ST_PARITY: w_tx_next = r_parity;
`endif
      default:   w_tx_next = 1'b1;
    endcase
  end

  // Shift register, bit/stop counters and the registered line driver
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_tx       <= w_tx_next;
    end
  end

`ifdef FIFO_UART_PARITY_EN
  // Capture the even-parity bit of the word as it is loaded
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      r_parity <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_parity <= ^rd_data;
    end
  end
`endif

  // Completed-frame counter, saturating at all-ones
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      r_frame_cnt <= '0;
    end else if (w_tx_done && (r_frame_cnt != {CNT_W{1'b1}})) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // The pop strobe is held off while reset is asserted even though the
  // FSM already sits in IDLE.
  assign rd_en     = w_rd_en & rd_rst;
  assign tx        = r_tx;
  assign busy      = (r_state != ST_IDLE);
  assign tx_done   = w_tx_done;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fifo_uart_tx                                           |
// | Purpose  : Self-checking bench for fifo_uart_tx with a queue-based   |
// |            FIFO, a frame-level expected-waveform model, directed     |
// |            scenarios and a randomized traffic phase.                 |
// | Macro    : FIFO_UART_PARITY_EN selects the parity build.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int N     = 8;
  localparam int CPB   = 4;
  localparam int STOPB = 1;
  localparam int CW    = 16;

  logic          rd_clk  = 1'b0;
  logic          rd_rst  = 1'b0;
  logic          tx_en   = 1'b0;
  logic          fifo_Empty;
  logic [N-1:0]  rd_data = '0;
  logic          rd_en;
  logic          tx;
  logic          busy;
  logic          tx_done;
  logic [CW-1:0] frame_cnt;

  always #5 rd_clk = ~rd_clk;

  fifo_uart_tx #(
    .N            (N),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (STOPB),
    .CNT_W        (CW)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .tx_en      (tx_en),
    .fifo_Empty (fifo_Empty),
    .rd_data    (rd_data),
    .rd_en      (rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .frame_cnt  (frame_cnt)
  );

  // FIFO model storage
  logic [N-1:0] mem [0:4095];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign fifo_Empty = (rd_ptr == wr_ptr);

  int total    = 0;
  int bad      = 0;
  int cyc      = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;
  int pop_cyc[$];

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  exp_t          exp_q[$];
  logic [CW-1:0] m_cnt = '0;
  bit            pend  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input logic [N-1:0] w);
    if (wr_ptr < 4096) begin
      mem[wr_ptr] = w;
      wr_ptr++;
    end
  endtask

  // Expected per-cycle outputs for one frame: LOAD cycle, then every serial
  // bit held for CPB cycles, done flagged on the very last cycle.
  function automatic void build_frame(input logic [N-1:0] w);
    logic bits[$];
    exp_t e;
    e.tx = 1'b1; e.busy = 1'b1; e.done = 1'b0;
    exp_q.push_back(e);
    bits.push_back(1'b0);
    for (int i = 0; i < N; i++) bits.push_back(w[i]);
    if (P == 1) bits.push_back(^w);
    for (int s = 0; s < STOPB; s++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int k = 0; k < CPB; k++) begin
        e.tx   = bits[b];
        e.busy = 1'b1;
        e.done = (b == bits.size() - 1) && (k == CPB - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  // Per-cycle compare against the model, plus FIFO read-data delivery
  always @(negedge rd_clk) begin
    exp_t e;
    logic exp_rd;
    cyc++;
    if (!rd_rst) begin
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_cnt", frame_cnt, 0);
      exp_q.delete();
      m_cnt = '0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("frame_tx", tx, e.tx);
      chk("frame_busy", busy, e.busy);
      chk("frame_done", tx_done, e.done);
      chk("frame_rd_en", rd_en, 0);
      chk("frame_cnt", frame_cnt, m_cnt);
      if (e.done && (m_cnt != {CW{1'b1}})) m_cnt = m_cnt + 1'b1;
    end else begin
      exp_rd = tx_en && !fifo_Empty;
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", tx_done, 0);
      chk("idle_rd_en", rd_en, exp_rd);
      chk("idle_cnt", frame_cnt, m_cnt);
      if (exp_rd) build_frame(mem[rd_ptr]);
    end
    if (tx_done === 1'b1) done_cnt++;
    if (pend) begin
      rd_data = mem[rd_ptr];
      rd_ptr++;
      pend = 1'b0;
    end
    if (rd_en === 1'b1) begin
      pend = 1'b1;
      pop_cnt++;
      pop_cyc.push_back(cyc);
    end
  end

  task automatic wait_pop(input string name);
    int n = 0;
    do begin
      @(negedge rd_clk);
      n++;
    end while (rd_en !== 1'b1 && n < 500);
    chk(name, rd_en, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge rd_clk);
      n++;
    end while (busy !== 1'b0 && n < 500);
    chk(name, busy, 0);
    @(posedge rd_clk); #1;
  endtask

  // Called at the negedge of the pop cycle; samples tx mid-bit.
  task automatic sample_frame(input string name, input logic [10:0] want, input int nbits);
    logic [10:0] got;
    got = '0;
    repeat (2 + CPB / 2) @(negedge rd_clk);
    got[0] = tx;
    for (int k = 1; k < nbits; k++) begin
      repeat (CPB) @(negedge rd_clk);
      got[k] = tx;
    end
    chk(name, got, want);
  endtask

  initial begin
    int pc;
    int n;
    int s01;
    int s12;

    // Reset held with a word waiting and transmit enabled
    rd_rst = 1'b0;
    tx_en  = 1'b1;
    push(8'hA5);
    repeat (3) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_tx", tx, 1);
    chk("reset_cnt", frame_cnt, 0);
    @(posedge rd_clk); #1;
    rd_rst = 1'b1;
    @(negedge rd_clk);
    chk("first_pop", rd_en, 1);
    sample_frame("frame_A5", (P == 1) ? 11'h54A : 11'h34A, 10 + P);
    wait_idle("idle_A5");
    chk("cnt_A5", frame_cnt, 1);
    chk("done_pulses_A5", done_cnt, 1);

    // Word with odd population (parity bit 1 in the parity build)
    push(8'h07);
    wait_pop("pop_07");
    sample_frame("frame_07", (P == 1) ? 11'h60E : 11'h20E, 10 + P);
    wait_idle("idle_07");
    chk("cnt_07", frame_cnt, 2);

    // Three queued words back to back
    tx_en = 1'b0;
    push(8'h3C); push(8'hFF); push(8'h00);
    pop_cyc.delete();
    pc = pop_cnt;
    @(posedge rd_clk); #1;
    tx_en = 1'b1;
    n = 0;
    while (!(pop_cnt == pc + 3 && !busy) && n < 400) begin
      @(posedge rd_clk); #1;
      n++;
    end
    chk("three_pops", pop_cyc.size(), 3);
    s01 = (pop_cyc.size() >= 2) ? pop_cyc[1] - pop_cyc[0] : -1;
    s12 = (pop_cyc.size() >= 3) ? pop_cyc[2] - pop_cyc[1] : -1;
    chk("spacing_01", s01, (P == 1) ? 46 : 42);
    chk("spacing_12", s12, (P == 1) ? 46 : 42);
    chk("cnt_three", frame_cnt, 5);

    // Disable transmit in the middle of a frame
    push(8'h5A); push(8'hC3);
    wait_pop("pop_drop");
    repeat (2 + CPB + 6) @(posedge rd_clk);
    #1;
    tx_en = 1'b0;
    pc = pop_cnt;
    repeat (120) @(posedge rd_clk);
    #1;
    chk("no_pop_disabled", pop_cnt - pc, 0);
    chk("cnt_drop", frame_cnt, 6);
    chk("word_still_queued", fifo_Empty, 0);
    tx_en = 1'b1;
    @(negedge rd_clk);
    chk("reassert_pop", rd_en, 1);
    wait_idle("idle_reassert");
    chk("cnt_reassert", frame_cnt, 7);

    // Reset in the start bit
    push(8'h99);
    wait_pop("pop_rst");
    @(posedge rd_clk);
    @(posedge rd_clk); #1;
    chk("start_bit_low", tx, 0);
    rd_rst = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst = 1'b1;
    pc = pop_cnt;
    repeat (20) @(posedge rd_clk);
    #1;
    chk("no_pop_empty", pop_cnt - pc, 0);
    chk("cnt_after_rst", frame_cnt, 0);

    // Randomized traffic with enable toggles and rare reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(posedge rd_clk); #1;
      rd_rst = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 3) == 0 && (wr_ptr - rd_ptr) < 6) push(N'($urandom));
      if ($urandom_range(0, 24) == 0) tx_en = ~tx_en;
    end
    @(posedge rd_clk); #1;
    rd_rst = 1'b1;
    tx_en  = 1'b1;
    n = 0;
    while (!(fifo_Empty && !busy && !pend) && n < 3000) begin
      @(posedge rd_clk); #1;
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_empty", fifo_Empty, 1);
    chk("final_cnt", frame_cnt, m_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
